uni_reg4: RTL

UNI_REG4 -- requirements
Module: uni_reg4

---
 rtl/uni_reg4.sv | 101 ++++++++++
 1 files changed

// File: rtl/uni_reg4.sv
// rtl/uni_reg4.sv - universal register: load, shift, rotate, count, clear
// Single-edge latency; qbar is always the complement of q.
module uni_reg4 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             sout,
  output logic             tc,
  output logic             ovf
);

  localparam logic [2:0] M_HOLD  = 3'b000;
  localparam logic [2:0] M_LOAD  = 3'b001;
  localparam logic [2:0] M_SHL   = 3'b010;
  localparam logic [2:0] M_SHR   = 3'b011;
  localparam logic [2:0] M_UP    = 3'b100;
  localparam logic [2:0] M_DOWN  = 3'b101;
  localparam logic [2:0] M_ROTL  = 3'b110;
  localparam logic [2:0] M_CLR   = 3'b111;

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ONES = '1;

  logic [WIDTH-1:0] q_next;
  logic             sout_next;
  logic             ovf_next;
  logic             at_max;
  logic             at_min;

  assign at_max = (q == ONES);
  assign at_min = (q == ZERO);

  always_comb begin
    q_next    = q;
    sout_next = sout;
    ovf_next  = ovf;
    if (en) begin
      unique case (mode)
        M_HOLD: ;
        M_LOAD: begin
          q_next    = d;
          sout_next = 1'b0;
          ovf_next  = 1'b0;
        end
        M_SHL: begin
          q_next    = {q[WIDTH-2:0], sin};
          sout_next = q[WIDTH-1];
        end
        M_SHR: begin
          q_next    = {sin, q[WIDTH-1:1]};
          sout_next = q[0];
        end
        M_UP: begin
          q_next = q + ONE;
          if (at_max) ovf_next = 1'b1;
        end
        M_DOWN: begin
          q_next = q - ONE;
          if (at_min) ovf_next = 1'b1;
        end
        M_ROTL: begin
          q_next    = {q[WIDTH-2:0], q[WIDTH-1]};
          sout_next = q[WIDTH-1];
        end
        M_CLR: begin
          q_next    = ZERO;
          sout_next = 1'b0;
          ovf_next  = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q    <= ZERO;
      sout <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      q    <= q_next;
      sout <= sout_next;
      ovf  <= ovf_next;
    end
  end

  // Derived from q rather than stored, so it can never disagree with q.
  assign qbar = ~q;

  assign tc = !rst && en &&
              (((mode == M_UP) && at_max) || ((mode == M_DOWN) && at_min));

endmodule
